addr_route_stage: RTL and testbench

ADDR_ROUTE_STAGE -- requirements
Module: addr_route_stage

---
 rtl/addr_map_pkg.sv | 9 +
 rtl/addr_region_match.sv | 22 ++
 rtl/addr_route_stage.sv | 78 +++++++
 tb/tb_addr_route_stage.sv | 139 +++++++++++++
 4 files changed

// File: rtl/addr_map_pkg.sv
// addr_map_pkg: shared address type, destination-width helper and default two-region map
package addr_map_pkg;
  typedef logic [31:0] addr_t;
  localparam logic [0:1][31:0] DEF_MAP_BASE = {32'h0000_0000, 32'h1000_0000};
  localparam logic [0:1][31:0] DEF_MAP_END = {32'h0fff_ffff, 32'h1fff_ffff};
  function automatic int dest_w(input int slaves);
    return $clog2(slaves + 1);
  endfunction
endpackage

// File: rtl/addr_region_match.sv
// addr_region_match: combinational region compare with lowest-index priority; addr in, idx/hit out
module addr_region_match #(
  parameter int ADDR_WIDTH = 32,
  parameter int SLAVES = 2,
  parameter int DEST_W = 2,
  parameter logic [0:SLAVES-1][ADDR_WIDTH-1:0] MAP_BASE = '0,
  parameter logic [0:SLAVES-1][ADDR_WIDTH-1:0] MAP_END = '0
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DEST_W-1:0]     idx,
  output logic                  hit
);
  always_comb begin
    idx = '0;
    hit = 1'b0;
    for (int i = SLAVES - 1; i >= 0; i--)
      if (addr >= MAP_BASE[i] && addr <= MAP_END[i]) begin
        idx = DEST_W'(i);
        hit = 1'b1;
      end
  end
endmodule

// File: rtl/addr_route_stage.sv
// addr_route_stage: registered address decode stage with outstanding-count and destination-switch hazard
// Ports: ACLK/ARESET (sync, active high); s_addr/s_valid/s_ready upstream; m_addr/m_dest/m_decerr/m_valid/m_ready
// downstream; resp_done completion pulse; outstanding live count.
// Macro ADDR_ROUTE_DECERR_EN routes unmapped addresses to dest SLAVES with m_decerr=1; otherwise dest 0, no error.
module addr_route_stage
  import addr_map_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int SLAVES = 2,
  parameter logic [0:SLAVES-1][ADDR_WIDTH-1:0] ADDR_MAP_BASE = DEF_MAP_BASE,
  parameter logic [0:SLAVES-1][ADDR_WIDTH-1:0] ADDR_MAP_END = DEF_MAP_END,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                                 ACLK,
  input  logic                                 ARESET,
  input  logic [ADDR_WIDTH-1:0]                s_addr,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  output logic [ADDR_WIDTH-1:0]                m_addr,
  output logic [dest_w(SLAVES)-1:0]            m_dest,
  output logic                                 m_decerr,
  output logic                                 m_valid,
  input  logic                                 m_ready,
  input  logic                                 resp_done,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding
);
  localparam int DEST_W = dest_w(SLAVES);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  logic [DEST_W-1:0] idx, dec_dest, cur_dest;
  logic hit, dec_err, hazard, accept, inc, dec;
  addr_region_match #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .SLAVES(SLAVES),
    .DEST_W(DEST_W),
    .MAP_BASE(ADDR_MAP_BASE),
    .MAP_END(ADDR_MAP_END)
  ) u_match (
    .addr(s_addr),
    .idx(idx),
    .hit(hit)
  );
  always_comb begin
`ifdef ADDR_ROUTE_DECERR_EN
    dec_dest = hit ? idx : DEST_W'(SLAVES);
    dec_err = !hit;
`else
    dec_dest = hit ? idx : '0;
    dec_err = 1'b0;
`endif
    // a switch of destination waits until every transaction to the previous one has completed
    hazard = (outstanding != '0 && dec_dest != cur_dest) || outstanding == CNT_W'(MAX_OUTSTANDING);
    s_ready = !ARESET && (!m_valid || m_ready) && !hazard;
    accept = s_valid && s_ready;
    inc = accept;
    dec = resp_done && outstanding != '0;
  end
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      m_valid <= 1'b0;
      m_addr <= '0;
      m_dest <= '0;
      m_decerr <= 1'b0;
      cur_dest <= '0;
      outstanding <= '0;
    end else begin
      if (accept) begin
        m_valid <= 1'b1;
        m_addr <= s_addr;
        m_dest <= dec_dest;
        m_decerr <= dec_err;
        cur_dest <= dec_dest;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
      outstanding <= (inc && !dec) ? outstanding + CNT_W'(1) : (dec && !inc) ? outstanding - CNT_W'(1) : outstanding;
    end
  end
endmodule

// File: tb/tb_addr_route_stage.sv
// tb_addr_route_stage: directed vector table plus hand sequences for hazard, fill, stall and reset
module tb_addr_route_stage;
  logic ACLK = 1'b0, ARESET, s_valid, s_ready, m_decerr, m_valid, m_ready, resp_done;
  logic [31:0] s_addr, m_addr;
  logic [1:0] m_dest;
  logic [3:0] outstanding;
  int tests = 0, fails = 0;
  typedef struct {
    logic [31:0] addr;
    logic [1:0]  dest;
    logic        err;
  } vec_t;
  vec_t vecs[7];
`ifdef ADDR_ROUTE_DECERR_EN
  localparam logic [1:0] UD = 2'd2;
  localparam logic UE = 1'b1;
`else
  localparam logic [1:0] UD = 2'd0;
  localparam logic UE = 1'b0;
`endif
  always #5 ACLK = ~ACLK;
  addr_route_stage dut (
    .ACLK(ACLK), .ARESET(ARESET), .s_addr(s_addr), .s_valid(s_valid), .s_ready(s_ready),
    .m_addr(m_addr), .m_dest(m_dest), .m_decerr(m_decerr), .m_valid(m_valid), .m_ready(m_ready),
    .resp_done(resp_done), .outstanding(outstanding)
  );
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic step;
    @(posedge ACLK);
    #1;
  endtask
  task automatic chk_zero(input string n);
    chk({n, " m_valid"}, m_valid, 0);
    chk({n, " m_addr"}, m_addr, 0);
    chk({n, " m_dest"}, m_dest, 0);
    chk({n, " m_decerr"}, m_decerr, 0);
    chk({n, " outstanding"}, outstanding, 0);
  endtask
  initial begin
    vecs[0] = '{32'h0000_0000, 2'd0, 1'b0};
    vecs[1] = '{32'h0fff_ffff, 2'd0, 1'b0};
    vecs[2] = '{32'h1000_0000, 2'd1, 1'b0};
    vecs[3] = '{32'h1000_0004, 2'd1, 1'b0};
    vecs[4] = '{32'h1fff_ffff, 2'd1, 1'b0};
    vecs[5] = '{32'h2000_0000, UD, UE};
    vecs[6] = '{32'hffff_ffff, UD, UE};
    ARESET = 1'b1; s_valid = 1'b1; s_addr = 32'h1000_0000; m_ready = 1'b1; resp_done = 1'b1;
    #1 chk("reset s_ready", s_ready, 0);
    step;
    step;
    chk_zero("reset");
    ARESET = 1'b0; s_valid = 1'b0; resp_done = 1'b0;
    for (int i = 0; i < 7; i++) begin
      s_valid = 1'b1; s_addr = vecs[i].addr;
      #1 chk("vec s_ready", s_ready, 1);
      step;
      s_valid = 1'b0;
      chk("vec m_valid", m_valid, 1);
      chk("vec m_addr", m_addr, vecs[i].addr);
      chk("vec m_dest", m_dest, vecs[i].dest);
      chk("vec m_decerr", m_decerr, vecs[i].err);
      chk("vec outstanding", outstanding, 1);
      resp_done = 1'b1;
      step;
      resp_done = 1'b0;
      chk("vec drain m_valid", m_valid, 0);
      chk("vec drain outstanding", outstanding, 0);
    end
    s_valid = 1'b1; s_addr = 32'h0000_0100;
    step;
    step;
    s_addr = 32'h1000_0000;
    #1 chk("haz s_ready", s_ready, 0);
    chk("haz outstanding", outstanding, 2);
    repeat (2) step;
    chk("haz hold s_ready", s_ready, 0);
    resp_done = 1'b1;
    step;
    resp_done = 1'b0;
    chk("haz one done outstanding", outstanding, 1);
    chk("haz one done s_ready", s_ready, 0);
    resp_done = 1'b1;
    step;
    resp_done = 1'b0;
    chk("haz clear outstanding", outstanding, 0);
    chk("haz clear s_ready", s_ready, 1);
    step;
    s_valid = 1'b0;
    chk("haz accept m_dest", m_dest, 1);
    chk("haz accept m_valid", m_valid, 1);
    chk("haz accept outstanding", outstanding, 1);
    resp_done = 1'b1;
    step;
    resp_done = 1'b0;
    s_valid = 1'b1; s_addr = 32'h0000_0040;
    repeat (8) step;
    chk("full outstanding", outstanding, 8);
    chk("full s_ready", s_ready, 0);
    resp_done = 1'b1;
    step;
    chk("full done outstanding", outstanding, 7);
    chk("full reopen s_ready", s_ready, 1);
    step;
    resp_done = 1'b0;
    chk("accept+done outstanding", outstanding, 7);
    step;
    s_valid = 1'b0;
    chk("refill outstanding", outstanding, 8);
    resp_done = 1'b1;
    repeat (8) step;
    chk("drained outstanding", outstanding, 0);
    step;
    resp_done = 1'b0;
    chk("underflow outstanding", outstanding, 0);
    m_ready = 1'b0; s_valid = 1'b1; s_addr = 32'h1000_0010;
    step;
    s_addr = 32'h1000_0020;
    repeat (3) begin
      chk("stall m_valid", m_valid, 1);
      chk("stall m_addr", m_addr, 32'h1000_0010);
      chk("stall m_dest", m_dest, 1);
      chk("stall s_ready", s_ready, 0);
      step;
    end
    ARESET = 1'b1;
    #1 chk("stall reset s_ready", s_ready, 0);
    step;
    chk_zero("stall reset");
    ARESET = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
